// File: rtl/radar_chirp_gen_if.sv
// Control/status bundle between waveform-select logic and radar_chirp_gen.
// master drives the chirp setup and start/abort; slave is the generator side.
interface radar_chirp_gen_if #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned CNT_W   = 24
);
    logic               start;
    logic               abort;
    logic [2:0]         mode;
    logic [PHASE_W-1:0] f_start;
    logic [PHASE_W-1:0] k_rate;
    logic [CNT_W-1:0]   pulse_len;
    logic [CNT_W-1:0]   pri_len;
    logic [15:0]        n_pulses;
    logic               busy;
    logic [ADDR_W-1:0]  phase_addr;
    logic               addr_valid;
    logic               pulse_start;
    logic               frame_done;

    modport master (
        output start, abort, mode, f_start, k_rate, pulse_len, pri_len, n_pulses,
        input  busy, phase_addr, addr_valid, pulse_start, frame_done
    );

    modport slave (
        input  start, abort, mode, f_start, k_rate, pulse_len, pri_len, n_pulses,
        output busy, phase_addr, addr_valid, pulse_start, frame_done
    );
endinterface

// File: rtl/radar_chirp_gen.sv
// Pulsed radar DDS phase-address generator (CW / LFM up / LFM down / triangle / NLFM)
// with PRI timer and pulse-train counter. Define RADAR_COHERENT_EN for pulse-to-pulse coherent phase.
module radar_chirp_gen #(
    parameter int unsigned        PHASE_W  = 32,
    parameter int unsigned        ADDR_W   = 12,
    parameter int unsigned        CNT_W    = 24,
    parameter logic [PHASE_W-1:0] P_OFFSET = '0
) (
    input logic               clk,
    input logic               rst,
    radar_chirp_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [2:0]         mode_q;
    logic [PHASE_W-1:0] f_start_q;
    logic [PHASE_W-1:0] k_rate_q;
    logic [CNT_W-1:0]   le_q;
    logic [CNT_W-1:0]   pe_q;
    logic [15:0]        n_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] freq_q;
    logic [CNT_W-1:0]   cyc_q;
    logic [15:0]        pcount_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               valid_q;
    logic               pstart_q;
    logic               fdone_q;
    logic               busy_q;

    logic [CNT_W-1:0]   le_d;
    logic [CNT_W-1:0]   pe_d;
    logic [PHASE_W-1:0] freq_d;
    logic [PHASE_W-1:0] phase_off_d;
    logic [15:0]        pcount_d;
    logic               pulse_last_d;
    logic               pri_end_d;
    logic               train_end_d;
    logic               nlfm_wide_d;

    assign bus.busy        = busy_q;
    assign bus.phase_addr  = addr_q;
    assign bus.addr_valid  = valid_q;
    assign bus.pulse_start = pstart_q;
    assign bus.frame_done  = fdone_q;

    always_comb begin
        le_d         = (bus.pulse_len == '0) ? CNT_W'(1) : bus.pulse_len;
        pe_d         = (bus.pri_len < le_d) ? le_d : bus.pri_len;
        phase_off_d  = phase_q + P_OFFSET;
        pcount_d     = pcount_q + 16'd1;
        train_end_d  = (n_q != '0) && (pcount_d == n_q);
        pulse_last_d = (cyc_q == le_q - CNT_W'(1));
        // With Pe == Le the PRI ends on the last sample, so GAP is never entered.
        pri_end_d    = ((state_q == S_PULSE) && pulse_last_d && (pe_q == le_q)) ||
                       ((state_q == S_GAP) && (cyc_q == pe_q - CNT_W'(1)));
        nlfm_wide_d  = (cyc_q < (le_q >> 2)) || (cyc_q >= le_q - (le_q >> 2));

        freq_d = freq_q;
        case (mode_q)
            3'd1:    freq_d = freq_q + k_rate_q;
            3'd2:    freq_d = freq_q - k_rate_q;
            3'd3:    freq_d = (cyc_q < (le_q >> 1)) ? freq_q + k_rate_q : freq_q - k_rate_q;
            3'd4:    freq_d = nlfm_wide_d ? freq_q + (k_rate_q << 1) : freq_q + (k_rate_q >> 1);
            default: freq_d = freq_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            f_start_q <= '0;
            k_rate_q  <= '0;
            le_q      <= '0;
            pe_q      <= '0;
            n_q       <= '0;
            phase_q   <= '0;
            freq_q    <= '0;
            cyc_q     <= '0;
            pcount_q  <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            pstart_q  <= 1'b0;
            fdone_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            addr_q   <= '0;
            valid_q  <= 1'b0;
            pstart_q <= 1'b0;
            fdone_q  <= 1'b0;
            if (bus.abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            mode_q    <= bus.mode;
                            f_start_q <= bus.f_start;
                            k_rate_q  <= bus.k_rate;
                            le_q      <= le_d;
                            pe_q      <= pe_d;
                            n_q       <= bus.n_pulses;
                            busy_q    <= 1'b1;
                            state_q   <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        phase_q  <= '0;
                        freq_q   <= f_start_q;
                        cyc_q    <= '0;
                        pcount_q <= '0;
                        state_q  <= S_PULSE;
                    end
                    S_PULSE: begin
                        addr_q   <= phase_off_d[PHASE_W-1 -: ADDR_W];
                        valid_q  <= 1'b1;
                        pstart_q <= (cyc_q == '0);
                        phase_q  <= phase_q + freq_q;
                        freq_q   <= freq_d;
                        cyc_q    <= cyc_q + CNT_W'(1);
                        if (pulse_last_d) begin
                            freq_q  <= f_start_q;
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        phase_q <= phase_q + freq_q;
                        cyc_q   <= cyc_q + CNT_W'(1);
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
                // End of PRI overrides the per-state updates above.
                if (pri_end_d) begin
                    pcount_q <= pcount_d;
                    cyc_q    <= '0;
                    freq_q   <= f_start_q;
                    if (train_end_d) begin
                        fdone_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_PULSE;
`ifdef RADAR_COHERENT_EN
                        phase_q <= phase_q + freq_q;
`else
                        phase_q <= '0;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_radar_chirp_gen.sv
// Self-checking bench for radar_chirp_gen: per-cycle comparison against a
// behavioural model built from the waveform rules, plus directed address tables.
module tb_radar_chirp_gen;

    localparam int MAXT = 512;
    localparam logic [31:0] P_OFF = 32'h0;
`ifdef RADAR_COHERENT_EN
    localparam bit COH = 1'b1;
`else
    localparam bit COH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    radar_chirp_gen_if #(.PHASE_W(32), .ADDR_W(12), .CNT_W(24)) bus_if ();

    radar_chirp_gen #(
        .PHASE_W (32),
        .ADDR_W  (12),
        .CNT_W   (24),
        .P_OFFSET(P_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int checks = 0;
    int failures = 0;

    logic        e_valid [MAXT];
    logic        e_pstart[MAXT];
    logic        e_fdone [MAXT];
    logic        e_busy  [MAXT];
    logic [11:0] e_addr  [MAXT];
    logic [11:0] obs_addr[MAXT];
    int nobs, n_ps, n_fd;

    logic [11:0] tab_lfm[6] = '{12'd0, 12'd0, 12'd1, 12'd3, 12'd6, 12'd10};
    logic [11:0] tab_tri[8] = '{12'd0, 12'd0, 12'd1, 12'd3, 12'd6, 12'd10, 12'd13, 12'd15};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] step_of(input logic [2:0] m, input int i, input int le,
                                            input logic [31:0] k);
        case (m)
            3'd1:    return k;
            3'd2:    return 32'd0 - k;
            3'd3:    return (i < le / 2) ? k : 32'd0 - k;
            3'd4:    return (i < le / 4 || i >= le - le / 4) ? k * 2 : k / 2;
            default: return 32'd0;
        endcase
    endfunction

    // Expected outputs indexed by cycles after start acceptance (t=0 is the ARM cycle).
    task automatic build_model(input logic [2:0] m, input logic [31:0] f, input logic [31:0] k,
                               input logic [23:0] pl, input logic [23:0] pr, input logic [15:0] n,
                               input int npl_cont, output int t_end, output int pe_o);
        int le, pe, npl, t;
        logic [31:0] base, ph, fr, tmp;
        le  = (pl == 24'd0) ? 1 : int'(pl);
        pe  = (int'(pr) < le) ? le : int'(pr);
        npl = (n == 16'd0) ? npl_cont : int'(n);
        for (int j = 0; j < MAXT; j++) begin
            e_valid[j] = 1'b0; e_pstart[j] = 1'b0; e_fdone[j] = 1'b0;
            e_busy[j] = 1'b0; e_addr[j] = 12'd0;
        end
        base = 32'd0;
        for (int p = 0; p < npl; p++) begin
            ph = base;
            fr = f;
            for (int i = 0; i < le; i++) begin
                t = 2 + p * pe + i;
                if (t < MAXT) begin
                    tmp         = ph + P_OFF;
                    e_valid[t]  = 1'b1;
                    e_pstart[t] = (i == 0);
                    e_addr[t]   = tmp[31:20];
                end
                ph = ph + fr;
                fr = fr + step_of(m, i, le, k);
            end
            base = COH ? ph + 32'(pe - le) * f : 32'd0;
        end
        for (int j = 0; j <= 1 + npl * pe && j < MAXT; j++) e_busy[j] = 1'b1;
        if (n != 16'd0 && 1 + npl * pe < MAXT) e_fdone[1 + npl * pe] = 1'b1;
        t_end = 2 + npl * pe;
        pe_o  = pe;
    endtask

    task automatic run_train(input logic [2:0] m, input logic [31:0] f, input logic [31:0] k,
                             input logic [23:0] pl, input logic [23:0] pr, input logic [15:0] n,
                             input int abort_t);
        int t_end, pe;
        build_model(m, f, k, pl, pr, n, abort_t + 2, t_end, pe);
        if (abort_t >= 0) begin
            t_end = abort_t + 1;
            e_valid[t_end] = 1'b0; e_pstart[t_end] = 1'b0; e_fdone[t_end] = 1'b0;
            e_busy[t_end] = 1'b0; e_addr[t_end] = 12'd0;
        end
        if (t_end >= MAXT) t_end = MAXT - 1;
        bus_if.mode = m; bus_if.f_start = f; bus_if.k_rate = k;
        bus_if.pulse_len = pl; bus_if.pri_len = pr; bus_if.n_pulses = n;
        bus_if.start = 1'b1; bus_if.abort = 1'b0;
        nobs = 0; n_ps = 0; n_fd = 0;
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            check($sformatf("addr_valid[t=%0d]", t), 32'(bus_if.addr_valid), 32'(e_valid[t]));
            check($sformatf("phase_addr[t=%0d]", t), 32'(bus_if.phase_addr), 32'(e_addr[t]));
            check($sformatf("pulse_start[t=%0d]", t), 32'(bus_if.pulse_start), 32'(e_pstart[t]));
            check($sformatf("frame_done[t=%0d]", t), 32'(bus_if.frame_done), 32'(e_fdone[t]));
            check($sformatf("busy[t=%0d]", t), 32'(bus_if.busy), 32'(e_busy[t]));
            if (bus_if.addr_valid === 1'b1 && nobs < MAXT) begin
                obs_addr[nobs] = bus_if.phase_addr;
                nobs++;
            end
            n_ps += int'(bus_if.pulse_start === 1'b1);
            n_fd += int'(bus_if.frame_done === 1'b1);
            // Latched setup must be immune to input changes while busy.
            bus_if.mode = 3'($urandom); bus_if.f_start = $urandom; bus_if.k_rate = $urandom;
            bus_if.pulse_len = 24'($urandom); bus_if.pri_len = 24'($urandom);
            bus_if.n_pulses = 16'($urandom);
            bus_if.start = (t < t_end - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_if.abort = (t == abort_t);
            if (t == abort_t) bus_if.start = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.mode = 3'd0;
        bus_if.f_start = '0; bus_if.k_rate = '0; bus_if.pulse_len = '0;
        bus_if.pri_len = '0; bus_if.n_pulses = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_valid", 32'(bus_if.addr_valid), 32'd0);
        check("reset_addr", 32'(bus_if.phase_addr), 32'd0);
        check("reset_pstart", 32'(bus_if.pulse_start), 32'd0);
        check("reset_fdone", 32'(bus_if.frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_train(3'd0, 32'h0100_0000, 32'd0, 24'd8, 24'd8, 16'd1, -1);
        check("cw_count", 32'(nobs), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("cw_addr%0d", i), 32'(obs_addr[i]), 32'(i * 16));
        check("cw_fdone_count", 32'(n_fd), 32'd1);

        run_train(3'd1, 32'd0, 32'h0010_0000, 24'd6, 24'd0, 16'd1, -1);
        check("lfm_count", 32'(nobs), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("lfm_addr%0d", i), 32'(obs_addr[i]), 32'(tab_lfm[i]));

        run_train(3'd3, 32'd0, 32'h0010_0000, 24'd8, 24'd8, 16'd1, -1);
        check("tri_count", 32'(nobs), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("tri_addr%0d", i), 32'(obs_addr[i]), 32'(tab_tri[i]));

        run_train(3'd2, 32'h0200_0000, 32'h0003_0000, 24'd4, 24'd10, 16'd3, -1);
        check("train_pstarts", 32'(n_ps), 32'd3);
        check("train_fdone", 32'(n_fd), 32'd1);
        check("train_samples", 32'(nobs), 32'd12);

        run_train(3'd1, 32'h0040_0000, 32'h0008_0000, 24'd4, 24'd2, 16'd3, -1);
        check("b2b_pstarts", 32'(n_ps), 32'd3);
        check("b2b_samples", 32'(nobs), 32'd12);

        run_train(3'd4, 32'h0010_0000, 32'h0020_0000, 24'd9, 24'd11, 16'd2, -1);
        run_train(3'd6, $urandom, $urandom, 24'd0, 24'd0, 16'd2, -1);

        // Abort on the 2nd sample of pulse 2 (Pe = 10) with start held high.
        run_train(3'd1, 32'h0010_0000, 32'h0004_0000, 24'd4, 24'd10, 16'd0, 12);
        check("abort_no_fdone", 32'(n_fd), 32'd0);
        run_train(3'd0, 32'h0300_0000, 32'd0, 24'd3, 24'd5, 16'd1, -1);

        bus_if.start = 1'b1; bus_if.abort = 1'b1;
        @(negedge clk);
        check("idle_abort_wins_busy", 32'(bus_if.busy), 32'd0);
        check("idle_abort_wins_valid", 32'(bus_if.addr_valid), 32'd0);
        bus_if.start = 1'b0; bus_if.abort = 1'b0;
        @(negedge clk);

`ifdef RADAR_COHERENT_EN
        run_train(3'd0, 32'h0100_0000, 32'd0, 24'd2, 24'd4, 16'd2, -1);
        check("coh_pulse2_addr", 32'(obs_addr[2]), 32'd64);
`endif

        for (int r = 0; r < 20; r++) begin
            run_train(3'($urandom_range(0, 7)), $urandom, $urandom,
                      24'($urandom_range(0, 12)), 24'($urandom_range(0, 24)),
                      16'($urandom_range(1, 3)), -1);
        end

        bus_if.mode = 3'd1; bus_if.f_start = 32'h0100_0000; bus_if.k_rate = 32'h0010_0000;
        bus_if.pulse_len = 24'd8; bus_if.pri_len = 24'd12; bus_if.n_pulses = 16'd2;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus_if.busy), 32'd0);
        check("async_rst_valid", 32'(bus_if.addr_valid), 32'd0);
        check("async_rst_addr", 32'(bus_if.phase_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_train(3'd4, 32'h0001_0000, 32'h0040_0000, 24'd12, 24'd14, 16'd2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
